change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser_pkg.sv | 16 +
 rtl/change_dispenser_coin_selector.sv | 31 +++
 rtl/change_dispenser.sv | 134 +++++++++++++
 tb/tb_change_dispenser.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/change_dispenser_pkg.sv
// Shared vending-machine definitions: default coin set, widths, timeout and FSM state type.
package change_dispenser_pkg;

    localparam int                DEF_NUM_COINS   = 3;
    localparam int                DEF_TOTAL_BITS  = 31;
    localparam int                DEF_WAIT_TIME   = 10;
    localparam int                DEF_STOCK_BITS  = 8;
    localparam int                DEF_INIT_STOCK  = 8;
    localparam logic [3*32-1:0]   DEF_COIN_VALUES = {32'd1000, 32'd500, 32'd100};

    typedef enum logic {
        ST_COUNT    = 1'b0,
        ST_DISPENSE = 1'b1
    } state_t;

endpackage

// File: rtl/change_dispenser_coin_selector.sv
// Combinational priority pick of the largest coin that is in stock and fits in the remainder.
module coin_selector
    import change_dispenser_pkg::*;
#(
    parameter int                          NUM_COINS   = DEF_NUM_COINS,
    parameter int                          TOTAL_BITS  = DEF_TOTAL_BITS,
    parameter logic [NUM_COINS*32-1:0]     COIN_VALUES = DEF_COIN_VALUES
) (
    input  logic [TOTAL_BITS-1:0] i_rem,
    input  logic [NUM_COINS-1:0]  i_avail,
    output logic [NUM_COINS-1:0]  o_onehot,
    output logic [TOTAL_BITS-1:0] o_value,
    output logic                  o_valid
);

    always_comb begin
        o_onehot = '0;
        o_value  = '0;
        o_valid  = 1'b0;
        // Ascending scan: the last eligible index wins, giving the highest denomination.
        for (int k = 0; k < NUM_COINS; k++) begin
            if (i_avail[k] && (64'(COIN_VALUES[k*32 +: 32]) <= 64'(i_rem))) begin
                o_onehot    = '0;
                o_onehot[k] = 1'b1;
                o_value     = TOTAL_BITS'(COIN_VALUES[k*32 +: 32]);
                o_valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: idle countdown / user trigger starts a greedy one-coin-per-cycle payout.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int                          NUM_COINS   = DEF_NUM_COINS,
    parameter int                          TOTAL_BITS  = DEF_TOTAL_BITS,
    parameter int                          WAIT_TIME   = DEF_WAIT_TIME,
    parameter logic [NUM_COINS*32-1:0]     COIN_VALUES = DEF_COIN_VALUES,
    parameter int                          STOCK_BITS  = DEF_STOCK_BITS,
    parameter int                          INIT_STOCK  = DEF_INIT_STOCK
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_COINS-1:0]  i_input_coin,
    input  logic                  i_item_dispensed,
    input  logic                  i_trigger_return,
    input  logic [TOTAL_BITS-1:0] i_current_total,
    output logic [NUM_COINS-1:0]  o_return_coin,
    output logic [TOTAL_BITS-1:0] o_total_dec,
    output logic [31:0]           o_wait_time,
    output logic                  o_busy,
    output logic                  o_stuck
);

    state_t                r_state, w_state_nxt;
    logic [31:0]           r_wait, w_wait_nxt;
    logic [TOTAL_BITS-1:0] r_rem, w_rem_nxt;
    logic [TOTAL_BITS-1:0] r_dec, w_dec_nxt;
    logic [NUM_COINS-1:0]  r_ret, w_ret_nxt;
    logic                  r_stuck, w_stuck_nxt;
    logic [STOCK_BITS-1:0] r_stock [NUM_COINS];

    logic [NUM_COINS-1:0]  w_stock_nz;
    logic [NUM_COINS-1:0]  w_sel_onehot;
    logic [TOTAL_BITS-1:0] w_sel_value;
    logic                  w_sel_valid;

    always_comb begin
        for (int k = 0; k < NUM_COINS; k++) begin
            w_stock_nz[k] = (r_stock[k] != '0);
        end
    end

    coin_selector #(
        .NUM_COINS   (NUM_COINS),
        .TOTAL_BITS  (TOTAL_BITS),
        .COIN_VALUES (COIN_VALUES)
    ) u_coin_selector (
        .i_rem    (r_rem),
        .i_avail  (w_stock_nz),
        .o_onehot (w_sel_onehot),
        .o_value  (w_sel_value),
        .o_valid  (w_sel_valid)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_rem_nxt   = r_rem;
        w_ret_nxt   = '0;
        w_dec_nxt   = '0;
        w_stuck_nxt = r_stuck;
        case (r_state)
            ST_COUNT: begin
                if ((i_input_coin != '0) || i_item_dispensed) begin
                    w_wait_nxt = 32'(WAIT_TIME);
                end else if ((i_current_total != '0) && (i_trigger_return || (r_wait == '0))) begin
                    w_state_nxt = ST_DISPENSE;
                    w_rem_nxt   = i_current_total;
                    w_stuck_nxt = 1'b0;
                    w_wait_nxt  = '0;
                end else if (r_wait != '0) begin
                    w_wait_nxt = r_wait - 32'd1;
                end
            end
            ST_DISPENSE: begin
                if (w_sel_valid) begin
                    w_ret_nxt = w_sel_onehot;
                    w_dec_nxt = w_sel_value;
                    w_rem_nxt = r_rem - w_sel_value;
                end else begin
                    w_stuck_nxt = (r_rem != '0);
                    w_wait_nxt  = 32'(WAIT_TIME);
                    w_state_nxt = ST_COUNT;
                end
            end
            default: w_state_nxt = ST_COUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_state <= ST_COUNT;
            r_wait  <= 32'(WAIT_TIME);
            r_rem   <= '0;
            r_ret   <= '0;
            r_dec   <= '0;
            r_stuck <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            r_rem   <= w_rem_nxt;
            r_ret   <= w_ret_nxt;
            r_dec   <= w_dec_nxt;
            r_stuck <= w_stuck_nxt;
        end
    end

    // An insert and an eject of the same coin in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            for (int k = 0; k < NUM_COINS; k++) begin
                r_stock[k] <= STOCK_BITS'(INIT_STOCK);
            end
        end else begin
            for (int k = 0; k < NUM_COINS; k++) begin
                if (i_input_coin[k] && !w_ret_nxt[k]) begin
                    if (r_stock[k] != '1) begin
                        r_stock[k] <= r_stock[k] + 1'b1;
                    end
                end else if (!i_input_coin[k] && w_ret_nxt[k]) begin
                    r_stock[k] <= r_stock[k] - 1'b1;
                end
            end
        end
    end

    assign o_return_coin = r_ret;
    assign o_total_dec   = r_dec;
    assign o_wait_time   = r_wait;
    assign o_busy        = (r_state == ST_DISPENSE);
    assign o_stuck       = r_stuck;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized and directed bench for change_dispenser against a greedy-payout reference model.
module tb_change_dispenser;

    localparam int N_COIN = 3;
    localparam int WT     = 10;
    localparam int SMAX   = 255;
    localparam int VAL [N_COIN] = '{100, 500, 1000};

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    i_input_coin = '0;
    logic          i_item_dispensed = 1'b0;
    logic          i_trigger_return = 1'b0;
    logic [30:0]   i_current_total = '0;
    logic [2:0]    o_return_coin;
    logic [30:0]   o_total_dec;
    logic [31:0]   o_wait_time;
    logic          o_busy;
    logic          o_stuck;

    change_dispenser dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_input_coin     (i_input_coin),
        .i_item_dispensed (i_item_dispensed),
        .i_trigger_return (i_trigger_return),
        .i_current_total  (i_current_total),
        .o_return_coin    (o_return_coin),
        .o_total_dec      (o_total_dec),
        .o_wait_time      (o_wait_time),
        .o_busy           (o_busy),
        .o_stuck          (o_stuck)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    bit     m_paying;
    int     m_wait;
    longint m_rem;
    int     m_stock [N_COIN];
    int     m_ret;
    int     m_dec;
    bit     m_stuck;
    longint bal;
    int     pulses [$];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int pick;
        int ej [N_COIN];
        for (int k = 0; k < N_COIN; k++) ej[k] = 0;
        if (reset_n) begin
            m_paying = 0; m_wait = WT; m_rem = 0; m_ret = 0; m_dec = 0; m_stuck = 0;
            for (int k = 0; k < N_COIN; k++) m_stock[k] = 8;
            return;
        end
        if (!m_paying) begin
            m_ret = 0; m_dec = 0;
            if (i_input_coin != 0 || i_item_dispensed) begin
                m_wait = WT;
            end else if (i_current_total > 0 && (i_trigger_return || m_wait == 0)) begin
                m_paying = 1; m_rem = i_current_total; m_stuck = 0; m_wait = 0;
            end else if (m_wait > 0) begin
                m_wait = m_wait - 1;
            end
        end else begin
            pick = -1;
            for (int k = N_COIN - 1; k >= 0; k--)
                if (pick < 0 && VAL[k] <= m_rem && m_stock[k] > 0) pick = k;
            if (pick >= 0) begin
                m_ret = 1 << pick; m_dec = VAL[pick]; m_rem = m_rem - VAL[pick]; ej[pick] = 1;
            end else begin
                m_ret = 0; m_dec = 0; m_stuck = (m_rem != 0); m_wait = WT; m_paying = 0;
            end
        end
        for (int k = 0; k < N_COIN; k++) begin
            m_stock[k] = m_stock[k] - ej[k] + int'(i_input_coin[k]);
            if (m_stock[k] > SMAX) m_stock[k] = SMAX;
        end
    endtask

    task automatic cycle();
        int old_dec;
        @(posedge clk);
        old_dec = m_dec;
        model_step();
        for (int k = 0; k < N_COIN; k++) if (i_input_coin[k]) bal += VAL[k];
        bal = (bal >= old_dec) ? bal - old_dec : 0;
        #1;
        chk("ret",   o_return_coin, m_ret);
        chk("dec",   o_total_dec,   m_dec);
        chk("wait",  o_wait_time,   m_wait);
        chk("busy",  o_busy,        m_paying);
        chk("stuck", o_stuck,       m_stuck);
        if (o_return_coin != 0) pulses.push_back(int'(o_total_dec));
        i_current_total = bal[30:0];
    endtask

    task automatic drive(input logic [2:0] coin, input bit item, input bit trig, input bit rst);
        i_input_coin = coin; i_item_dispensed = item; i_trigger_return = trig; reset_n = rst;
        cycle();
        i_input_coin = '0; i_item_dispensed = 1'b0; i_trigger_return = 1'b0; reset_n = 1'b0;
    endtask

    task automatic set_bal(input longint v);
        bal = v;
        i_current_total = v[30:0];
    endtask

    task automatic idle(input int n);
        repeat (n) drive(3'b000, 0, 0, 0);
    endtask

    task automatic chk_pulses(input string tag, input int exp [$]);
        chk({tag, "_n"}, pulses.size(), exp.size());
        for (int i = 0; i < exp.size() && i < pulses.size(); i++) chk(tag, pulses[i], exp[i]);
    endtask

    initial begin
        m_paying = 0; m_wait = WT; m_rem = 0; m_ret = 0; m_dec = 0; m_stuck = 0; bal = 0;
        for (int k = 0; k < N_COIN; k++) m_stock[k] = 8;

        // Reset state
        set_bal(0);
        drive(3'b000, 0, 0, 1);
        drive(3'b000, 0, 0, 1);
        chk("rst_wait", o_wait_time, 10);
        chk("rst_ret", o_return_coin, 0);
        for (int k = 0; k < N_COIN; k++) chk("rst_stock", dut.r_stock[k], 8);

        // Idle timeout payout of 1600
        set_bal(1600);
        pulses.delete();
        idle(10);
        chk("to_wait0", o_wait_time, 0);
        idle(5);
        chk_pulses("to_pulse", '{1000, 500, 100});
        chk("to_wait", o_wait_time, 10);
        chk("to_stuck", o_stuck, 0);

        // Trigger with 700 in cycle 3
        drive(3'b000, 0, 0, 1);
        set_bal(700);
        pulses.delete();
        idle(2);
        drive(3'b000, 0, 1, 0);
        chk("tr_busy", o_busy, 1);
        idle(5);
        chk_pulses("tr_pulse", '{500, 100, 100});
        chk("tr_stuck", o_stuck, 0);

        // Empty the 1000 stock, then pay 2000 from 500s
        drive(3'b000, 0, 0, 1);
        set_bal(8000);
        drive(3'b000, 0, 1, 0);
        idle(10);
        chk("dep_s2", dut.r_stock[2], 0);
        set_bal(2000);
        pulses.delete();
        drive(3'b000, 0, 1, 0);
        idle(6);
        chk_pulses("dep_pulse", '{500, 500, 500, 500});
        chk("dep_s1", dut.r_stock[1], 4);

        // Unpayable 150, then coin+trigger in COUNT
        drive(3'b000, 0, 0, 1);
        set_bal(150);
        pulses.delete();
        drive(3'b000, 0, 1, 0);
        idle(3);
        chk_pulses("unp_pulse", '{100});
        chk("unp_stuck", o_stuck, 1);
        chk("unp_rem", dut.r_rem, 50);
        drive(3'b001, 0, 1, 0);
        chk("unp_busy", o_busy, 0);
        chk("unp_wait", o_wait_time, 10);

        // Reset in second payout cycle
        drive(3'b000, 0, 0, 1);
        set_bal(1600);
        idle(11);
        chk("mr_busy", o_busy, 1);
        idle(1);
        chk("mr_first", o_total_dec, 1000);
        set_bal(0);
        pulses.delete();
        drive(3'b000, 0, 0, 1);
        chk("mr_busy0", o_busy, 0);
        chk("mr_wait", o_wait_time, 10);
        for (int k = 0; k < N_COIN; k++) chk("mr_stock", dut.r_stock[k], 8);
        idle(3);
        chk("mr_npulse", pulses.size(), 0);

        // Stock saturation
        repeat (260) drive(3'b001, 0, 0, 0);
        chk("sat_s0", dut.r_stock[0], 255);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] c;
            c = {($urandom_range(0, 15) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0)};
            if (!m_paying && $urandom_range(0, 49) == 0) set_bal($urandom_range(0, 2500));
            drive(c, ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
